// File: rtl/masked_sbox_bram_sched_pkg.sv
// Shared constants for the masked S-box BRAM issue/collect stage.
// The default geometry is a 16-byte share, a 2-cycle BRAM read and a 10-bit address.
package masked_sbox_bram_sched_pkg;
  localparam int NBYTES = 16;
  localparam int LAT    = 2;
  localparam int AW     = 10;
  localparam int NPAIRS = NBYTES / 2;
  localparam int IDXW   = $clog2(NPAIRS);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPAIRS - 1);

  typedef logic [IDXW-1:0] pair_idx_t;
endpackage

// File: rtl/masked_sbox_bram_sched_vld_pipe.sv
// Delay line that tags each issued address pair with its pair index.
// The tag leaves the line in the same cycle that the BRAM presents that pair's data.
module masked_sbox_bram_sched_vld_pipe
  import masked_sbox_bram_sched_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      vld_i,
  input  pair_idx_t idx_i,
  output logic      vld_o,
  output pair_idx_t idx_o
);

  // Stage 0 is the issue cycle itself, so LAT registers complete a LAT+1-deep line.
  logic [LAT-1:0] vld_q;
  pair_idx_t      idx_q [LAT];

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < LAT; i++) idx_q[i] <= '0;
    end else begin
      vld_q[0] <= vld_i;
      idx_q[0] <= idx_i;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign vld_o = vld_q[LAT-1];
  assign idx_o = idx_q[LAT-1];

endmodule

// File: rtl/masked_sbox_bram_sched.sv
// Streams one masked 128-bit share through a dual-port S-box BRAM, two bytes per cycle,
// and reassembles the results. Handshake: start is a 1-cycle request honoured only when idle.
module masked_sbox_bram_sched
  import masked_sbox_bram_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [8*NBYTES-1:0] state_in,
  input  logic [2*NBYTES-1:0] sel_in,
  output logic                busy,
  output logic                done,
  output logic [8*NBYTES-1:0] state_out,
  output logic [AW-1:0]       ADDRA,
  output logic [AW-1:0]       ADDRB,
  output logic                bram_en,
  input  logic [7:0]          DOA,
  input  logic [7:0]          DOB
);

  logic [1:0]          fsm_q, fsm_d;
  pair_idx_t           idx_q, idx_d;
  logic [8*NBYTES-1:0] st_q, st_d;
  logic [2*NBYTES-1:0] sel_q, sel_d;
  logic [8*NBYTES-1:0] out_q, out_d;
  logic                done_q, done_d;

  logic                cap_vld;
  pair_idx_t           cap_idx;
  logic                last_cap;

  logic [IDXW+3:0]     byte_off_a, byte_off_b, cap_off_a, cap_off_b;
  logic [IDXW+1:0]     sel_off_a, sel_off_b;

  masked_sbox_bram_sched_vld_pipe u_vld_pipe (
    .clk   (clk),
    .rst   (rst),
    .vld_i (fsm_q == ISSUE),
    .idx_i (idx_q),
    .vld_o (cap_vld),
    .idx_o (cap_idx)
  );

  assign byte_off_a = {idx_q, 4'b0000};
  assign byte_off_b = {idx_q, 4'b1000};
  assign sel_off_a  = {idx_q, 2'b00};
  assign sel_off_b  = {idx_q, 2'b10};
  assign cap_off_a  = {cap_idx, 4'b0000};
  assign cap_off_b  = {cap_idx, 4'b1000};

  // Addresses follow idx, which is frozen on the last pair through DRAIN and IDLE.
  assign ADDRA = {sel_q[sel_off_a +: 2], st_q[byte_off_a +: 8]};
  assign ADDRB = {sel_q[sel_off_b +: 2], st_q[byte_off_b +: 8]};

  assign last_cap = cap_vld && (cap_idx == LAST_IDX);

  always_comb begin
    fsm_d  = fsm_q;
    idx_d  = idx_q;
    st_d   = st_q;
    sel_d  = sel_q;
    out_d  = out_q;
    done_d = last_cap;

    case (fsm_q)
      IDLE: begin
        if (start) begin
          fsm_d = ISSUE;
          idx_d = '0;
          st_d  = state_in;
          sel_d = sel_in;
        end
      end
      ISSUE: begin
        if (idx_q == LAST_IDX) fsm_d = DRAIN;
        else                   idx_d = idx_q + 1'b1;
      end
      DRAIN: begin
        if (last_cap) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase

    if (cap_vld) begin
      out_d[cap_off_a +: 8] = DOA;
      out_d[cap_off_b +: 8] = DOB;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      idx_q  <= '0;
      st_q   <= '0;
      sel_q  <= '0;
      out_q  <= '0;
      done_q <= 1'b0;
    end else begin
      fsm_q  <= fsm_d;
      idx_q  <= idx_d;
      st_q   <= st_d;
      sel_q  <= sel_d;
      out_q  <= out_d;
      done_q <= done_d;
    end
  end

  assign busy      = (fsm_q != IDLE);
  assign bram_en   = (fsm_q != IDLE);
  assign done      = done_q;
  assign state_out = out_q;

endmodule
